// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one data-memory port between two requesters: port 0 is the core
// load/store unit, port 1 is the DMA/debug master. The arbiter is the bus
// initiator on the memory side. It latches the winning request, holds
// Data_* stable until complete_data, and then returns read data and a
// one-cycle done pulse to the owner. Ties are broken round-robin. Port 0
// wins the first tie after reset.
//
// Optional feature (compile-time macro DMEM_ARB_TIMEOUT_EN):
//    An access that sits in BUSY for TIMEOUT_CYCLES cycles without
//    complete_data is aborted. The owner then sees done with err = 1.
//    If complete_data arrives in that same cycle, it wins and err = 0.
//    When the macro is not defined, err0/err1 are constant 0 and BUSY
//    waits indefinitely.
//
// Ports:
//    clock          in   system clock, rising edge
//    reset          in   asynchronous, active-low reset
//    req0/req1      in   access request, held until gnt
//    rd0/rd1        in   1 = read, 0 = write (sampled at grant)
//    addr0/addr1    in   access address (sampled at grant)
//    wdata0/wdata1  in   write data (sampled at grant)
//    gnt0/gnt1      out  one-cycle pulse: request accepted and latched
//    done0/done1    out  one-cycle pulse: access finished
//    rdata0/rdata1  out  read data, valid with done, held until next done
//    err0/err1      out  valid with done, 1 = access aborted by timeout
//    Data_addr      out  memory address
//    Data_din       out  memory write data
//    Data_rd        out  1 = read, 0 = write
//    mem_active     out  access in progress; Data_* meaningful only when high
//    Data_dout      in   memory read data
//    complete_data  in   memory access complete (sampled only in BUSY)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              rd0,
   input  logic              rd1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              err0,
   output logic              err1,
   output logic [ADDR_W-1:0] Data_addr,
   output logic [DATA_W-1:0] Data_din,
   output logic              Data_rd,
   output logic              mem_active,
   input  logic [DATA_W-1:0] Data_dout,
   input  logic              complete_data
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                owner_q, owner_d;
   logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                done0_q, done0_d, done1_q, done1_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                rd_q, rd_d;
   logic                active_q, active_d;

   logic                grant_valid_s;
   logic                grant_port_s;
   logic                timeout_s;

   // Round-robin pick: a lone requester always wins; on a tie the port
   // that did not finish the previous access wins.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_port_s  = 1'b0;
      if (req0 && req1) begin
         grant_valid_s = 1'b1;
         grant_port_s  = ~last_grant_q;
      end else if (req0) begin
         grant_valid_s = 1'b1;
         grant_port_s  = 1'b0;
      end else if (req1) begin
         grant_valid_s = 1'b1;
         grant_port_s  = 1'b1;
      end else begin
         grant_valid_s = 1'b0;
         grant_port_s  = 1'b0;
      end
   end

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   // The counter holds the number of BUSY cycles already spent without
   // completion. The abort fires in the cycle that would bring it to
   // TIMEOUT_CYCLES.
   localparam logic [CNT_W-1:0] TMO_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             err0_q, err0_d, err1_q, err1_d;

   // Timeout counter next state. The counter is held at zero outside BUSY,
   // so it always starts an access cleared.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      timeout_s = 1'b0;
      if (state_q != ST_BUSY) begin
         tmo_cnt_d = {CNT_W{1'b0}};
      end else if (complete_data) begin
         tmo_cnt_d = {CNT_W{1'b0}};
      end else if (tmo_cnt_q >= TMO_LAST) begin
         timeout_s = 1'b1;
         tmo_cnt_d = {CNT_W{1'b0}};
      end else begin
         tmo_cnt_d = tmo_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Timeout counter register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tmo_cnt_q <= {CNT_W{1'b0}};
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   // Error flag next state. The flag is updated only when the owner's
   // access ends; a real completion always clears it.
   always_comb begin
      err0_d = err0_q;
      err1_d = err1_q;
      if ((state_q == ST_BUSY) && (complete_data || timeout_s)) begin
         if (owner_q) begin
            err1_d = ~complete_data;
         end else begin
            err0_d = ~complete_data;
         end
      end else begin
         err0_d = err0_q;
         err1_d = err1_q;
      end
   end

   // Error flag registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err0_q <= 1'b0;
         err1_q <= 1'b0;
      end else begin
         err0_q <= err0_d;
         err1_q <= err1_d;
      end
   end

   assign err0 = err0_q;
   assign err1 = err1_q;
`else
   assign timeout_s = 1'b0;
   assign err0      = 1'b0;
   assign err1      = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid_s) begin
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (complete_data || timeout_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM output logic. This computes the next value of every registered
   // output. Pulses default low; data and bus fields hold their value.
   always_comb begin
      gnt0_d       = 1'b0;
      gnt1_d       = 1'b0;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      addr_d       = addr_q;
      din_d        = din_q;
      rd_d         = rd_q;
      active_d     = active_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid_s) begin
               owner_d  = grant_port_s;
               active_d = 1'b1;
               if (grant_port_s) begin
                  addr_d = addr1;
                  din_d  = wdata1;
                  rd_d   = rd1;
                  gnt1_d = 1'b1;
               end else begin
                  addr_d = addr0;
                  din_d  = wdata0;
                  rd_d   = rd0;
                  gnt0_d = 1'b1;
               end
            end else begin
               active_d = 1'b0;
            end
         end
         ST_BUSY: begin
            if (complete_data) begin
               // A write leaves the owner's rdata untouched.
               if (rd_q) begin
                  if (owner_q) begin
                     rdata1_d = Data_dout;
                  end else begin
                     rdata0_d = Data_dout;
                  end
               end else begin
                  rdata0_d = rdata0_q;
                  rdata1_d = rdata1_q;
               end
               if (owner_q) begin
                  done1_d = 1'b1;
               end else begin
                  done0_d = 1'b1;
               end
               active_d     = 1'b0;
               last_grant_d = owner_q;
            end else if (timeout_s) begin
               if (owner_q) begin
                  done1_d = 1'b1;
               end else begin
                  done0_d = 1'b1;
               end
               active_d     = 1'b0;
               last_grant_d = owner_q;
            end else begin
               active_d = 1'b1;
            end
         end
         default: begin
            active_d = 1'b0;
         end
      endcase
   end

   // Registered outputs and arbitration bookkeeping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         rdata0_q     <= {DATA_W{1'b0}};
         rdata1_q     <= {DATA_W{1'b0}};
         addr_q       <= {ADDR_W{1'b0}};
         din_q        <= {DATA_W{1'b0}};
         rd_q         <= 1'b1;
         active_q     <= 1'b0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         rd_q         <= rd_d;
         active_q     <= active_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign done0      = done0_q;
   assign done1      = done1_q;
   assign rdata0     = rdata0_q;
   assign rdata1     = rdata1_q;
   assign Data_addr  = addr_q;
   assign Data_din   = din_q;
   assign Data_rd    = rd_q;
   assign mem_active = active_q;

endmodule
